// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the multi-cycle memory sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_DATA,
    ST_COMMIT,
    ST_HALT
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  localparam logic [1:0] MSIZE_BYTE = 2'b01;
  localparam logic [1:0] MSIZE_HALF = 2'b10;
  localparam logic [1:0] MSIZE_WORD = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/mem_sequencer_lane_steer.sv
// Byte-lane steering: store strobes/replication, load right-shift, alignment check.
module lane_steer
  import mem_seq_pkg::*;
(
  input  logic [1:0]  i_memsize,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_mwdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  always_comb begin
    o_wstrb      = '0;
    o_mwdata     = '0;
    o_misaligned = 1'b0;
    case (i_memsize)
      MSIZE_BYTE: begin
        o_wstrb  = 4'b0001 << i_offset;
        o_mwdata = {4{i_wdata[7:0]}};
      end
      MSIZE_HALF: begin
        o_wstrb      = 4'b0011 << i_offset;
        o_mwdata     = {2{i_wdata[15:0]}};
        o_misaligned = i_offset[0];
      end
      // size 00 is not a legal encoding; treat it as a full word
      default: begin
        o_wstrb      = '1;
        o_mwdata     = i_wdata;
        o_misaligned = |i_offset;
      end
    endcase
    o_rdata = i_rdata >> {i_offset, 3'b000};
  end

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer placing a single-cycle RV32 core in front of one shared memory port.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_load,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  input  logic        i_halt_req,
  output logic [31:0] o_inst,
  output logic [31:0] o_rdata,
  output logic        o_cpu_en,
  output logic        o_req,
  output logic        o_we,
  output logic [31:0] o_maddr,
  output logic [31:0] o_mwdata,
  output logic [3:0]  o_wstrb,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic        o_halted,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic [31:0] o_retired
);

  state_t      r_state, w_next;
  logic        r_boot;
  logic        r_fault;
  logic [1:0]  r_cause;
  logic [31:0] r_inst, r_rdata, r_retired, r_tcnt;

  logic        w_req, w_set_fault, w_timeout, w_access, w_mis;
  logic [1:0]  w_cause;
  logic [3:0]  w_wstrb;
  logic [31:0] w_mwdata, w_rdata_sh;

  lane_steer u_lane_steer (
    .i_memsize    (i_memsize),
    .i_offset     (i_addr[1:0]),
    .i_wdata      (i_wdata),
    .i_rdata      (i_rdata),
    .o_wstrb      (w_wstrb),
    .o_mwdata     (w_mwdata),
    .o_rdata      (w_rdata_sh),
    .o_misaligned (w_mis)
  );

  assign w_access  = i_load | i_write;
  assign w_timeout = (TIMEOUT != 0) && (r_tcnt == TIMEOUT - 1);

  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_set_fault = 1'b0;
    w_cause     = CAUSE_NONE;
    case (r_state)
      ST_FETCH: begin
        if (i_pc[1:0] != 2'b00) begin
          w_set_fault = 1'b1;
          w_cause     = CAUSE_MISALIGN;
          w_next      = ST_HALT;
        end else if (!r_boot) begin
          // request is suppressed only in the first cycle after reset
          w_req = 1'b1;
          if (i_ack) begin
            w_next = ST_EXEC;
          end else if (w_timeout) begin
            w_set_fault = 1'b1;
            w_cause     = CAUSE_TIMEOUT;
            w_next      = ST_HALT;
          end
        end
      end
      ST_EXEC: begin
        if (w_access) begin
          if (w_mis) begin
            w_set_fault = 1'b1;
            w_cause     = CAUSE_MISALIGN;
            w_next      = ST_HALT;
          end else begin
            w_next = ST_DATA;
          end
        end else begin
          w_next = ST_COMMIT;
        end
      end
      ST_DATA: begin
        w_req = 1'b1;
        if (i_ack) begin
          w_next = ST_COMMIT;
        end else if (w_timeout) begin
          w_set_fault = 1'b1;
          w_cause     = CAUSE_TIMEOUT;
          w_next      = ST_HALT;
        end
      end
      ST_COMMIT: w_next = i_halt_req ? ST_HALT : ST_FETCH;
      ST_HALT:   if (!i_halt_req && !r_fault) w_next = ST_FETCH;
      default:   w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_FETCH;
      r_boot    <= 1'b1;
      r_fault   <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_inst    <= NOP_INST;
      r_rdata   <= '0;
      r_retired <= '0;
      r_tcnt    <= '0;
    end else begin
      r_state <= w_next;
      r_boot  <= 1'b0;
      if (w_set_fault) begin
        r_fault <= 1'b1;
        r_cause <= w_cause;
      end
      r_tcnt <= (w_req && !i_ack) ? r_tcnt + 32'd1 : '0;
      if (r_state == ST_FETCH && w_req && i_ack) r_inst <= i_rdata;
      if (r_state == ST_DATA && i_ack && !i_write) r_rdata <= w_rdata_sh;
      // counted on entry so the count already includes the instruction during its commit strobe
      if (w_next == ST_COMMIT) r_retired <= r_retired + 32'd1;
      if (r_state == ST_FETCH && r_boot) assert (i_pc == RESET_PC);
    end
  end

  assign o_req         = w_req;
  assign o_we          = w_req && (r_state == ST_DATA) && i_write;
  assign o_maddr       = !w_req ? '0 :
                         (r_state == ST_DATA) ? {i_addr[31:2], 2'b00} : {i_pc[31:2], 2'b00};
  assign o_wstrb       = o_we ? w_wstrb : '0;
  assign o_mwdata      = o_we ? w_mwdata : '0;
  assign o_cpu_en      = (r_state == ST_COMMIT);
  assign o_halted      = (r_state == ST_HALT);
  assign o_fault       = r_fault;
  assign o_fault_cause = r_cause;
  assign o_inst        = r_inst;
  assign o_rdata       = r_rdata;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: memory responder, commit monitor, directed instruction stream.
module tb_mem_sequencer;

  logic        i_clk;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc = '0;
  logic        i_load = 1'b0;
  logic        i_write = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [1:0]  i_memsize = 2'b11;
  logic        i_halt_req = 1'b0;
  logic        i_ack = 1'b0;
  logic [31:0] i_rdata = '0;
  logic [31:0] o_inst, o_rdata, o_maddr, o_mwdata, o_retired;
  logic        o_cpu_en, o_req, o_we, o_halted, o_fault;
  logic [3:0]  o_wstrb;
  logic [1:0]  o_fault_cause;

  mem_sequencer #(.TIMEOUT(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .i_load(i_load), .i_write(i_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_memsize(i_memsize), .i_halt_req(i_halt_req),
    .o_inst(o_inst), .o_rdata(o_rdata), .o_cpu_en(o_cpu_en), .o_req(o_req), .o_we(o_we),
    .o_maddr(o_maddr), .o_mwdata(o_mwdata), .o_wstrb(o_wstrb), .i_ack(i_ack), .i_rdata(i_rdata),
    .o_halted(o_halted), .o_fault(o_fault), .o_fault_cause(o_fault_cause), .o_retired(o_retired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] maddr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] mwdata;
  } req_t;

  typedef struct {
    logic [31:0] retired;
    logic [31:0] inst;
    logic        chk_rd;
    logic [31:0] rdata;
  } cm_t;

  req_t        req_q[$];
  cm_t         cm_q[$];
  int          n_checks = 0;
  int          n_errs = 0;
  int          ack_delay = 0;
  int          n_acks = 0;
  logic        force_ack = 1'b0;
  logic [31:0] exp_retired = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h8001_7777;
    return {a[23:0], 8'h93} ^ 32'h0050_0000;
  endfunction

  // memory responder: checks request fields every request cycle, acks after ack_delay cycles
  initial begin
    int   wcnt;
    req_t r;
    wcnt = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        i_ack = 1'b0;
        wcnt  = 0;
      end else if (o_req) begin
        if (req_q.size() == 0) begin
          check_eq("req_unexpected", 32'd1, 32'd0);
        end else begin
          r = req_q[0];
          check_eq("req_maddr", o_maddr, r.maddr);
          check_eq("req_we", {31'd0, o_we}, {31'd0, r.we});
          check_eq("req_wstrb", {28'd0, o_wstrb}, {28'd0, r.wstrb});
          check_eq("req_mwdata", o_mwdata, r.mwdata);
        end
        if (wcnt >= ack_delay) begin
          i_ack   = 1'b1;
          i_rdata = mem_rd(o_maddr);
          if (req_q.size() != 0) void'(req_q.pop_front());
          n_acks++;
        end else begin
          i_ack   = 1'b0;
          i_rdata = $urandom;
        end
        wcnt++;
      end else begin
        i_ack   = force_ack;
        i_rdata = $urandom;
        wcnt    = 0;
      end
    end
  end

  // commit monitor
  initial begin
    cm_t c;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_cpu_en) begin
        if (cm_q.size() == 0) begin
          check_eq("commit_unexpected", 32'd1, 32'd0);
        end else begin
          c = cm_q.pop_front();
          check_eq("commit_retired", o_retired, c.retired);
          check_eq("commit_inst", o_inst, c.inst);
          if (c.chk_rd) check_eq("commit_rdata", o_rdata, c.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_pc = '0; i_load = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    i_memsize = 2'b11; i_halt_req = 1'b0; force_ack = 1'b0; ack_delay = 0;
    req_q.delete();
    cm_q.delete();
    exp_retired = '0;
    repeat (2) @(negedge i_clk);
    check_eq("rst_req", {31'd0, o_req}, 32'd0);
    check_eq("rst_inst", o_inst, 32'h0000_0013);
    check_eq("rst_rdata", o_rdata, 32'd0);
    check_eq("rst_retired", o_retired, 32'd0);
    check_eq("rst_fault", {30'd0, o_fault, o_halted}, 32'd0);
    check_eq("rst_cause", {30'd0, o_fault_cause}, 32'd0);
    check_eq("rst_maddr", o_maddr, 32'd0);
    check_eq("rst_cpu_en", {31'd0, o_cpu_en}, 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check_eq("boot_req", {31'd0, o_req}, 32'd0);
  endtask

  task automatic exec_instr(input logic [31:0] pc, input logic ld, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input int delay, input logic halt_in_exec);
    logic [1:0] off;
    logic       acc, mis, done;
    req_t       r;
    cm_t        c;
    int         acks0, exp_lat, cyc;
    off = addr[1:0];
    acc = ld | wr;
    mis = acc && ((size == 2'b10 && off[0]) || (size == 2'b11 && off != 2'b00));
    r.maddr = pc; r.we = 1'b0; r.wstrb = 4'h0; r.mwdata = '0;
    req_q.push_back(r);
    if (acc && !mis) begin
      r.maddr = {addr[31:2], 2'b00};
      r.we = wr; r.wstrb = 4'h0; r.mwdata = '0;
      if (wr) begin
        if (size == 2'b01) begin
          r.wstrb[off] = 1'b1;
          for (int i = 0; i < 4; i++) r.mwdata[8*i +: 8] = wdata[7:0];
        end else if (size == 2'b10) begin
          r.wstrb[off] = 1'b1;
          r.wstrb[off + 2'd1] = 1'b1;
          for (int i = 0; i < 2; i++) r.mwdata[16*i +: 16] = wdata[15:0];
        end else begin
          r.wstrb = 4'hF;
          r.mwdata = wdata;
        end
      end
      req_q.push_back(r);
    end
    if (!mis) begin
      exp_retired++;
      c.retired = exp_retired;
      c.inst    = mem_rd(pc);
      c.chk_rd  = ld && !wr;
      c.rdata   = mem_rd({addr[31:2], 2'b00}) >> (8 * off);
      cm_q.push_back(c);
    end
    exp_lat = acc ? 4 + 2 * delay : 3 + delay;
    i_pc = pc; i_load = ld; i_write = wr; i_addr = addr; i_wdata = wdata; i_memsize = size;
    ack_delay = delay;
    acks0 = n_acks;
    done = 1'b0;
    cyc = 0;
    for (int j = 0; j < 64; j++) begin
      @(negedge i_clk);
      cyc++;
      if (halt_in_exec && n_acks != acks0 && !o_req) i_halt_req = 1'b1;
      if (o_cpu_en || o_halted) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("instr_done", {31'd0, done}, 32'd1);
    if (!mis) check_eq("latency", cyc, exp_lat);
  endtask

  initial begin
    int reqs;
    do_reset();
    exec_instr(32'h00, 1'b0, 1'b0, 32'h0,   32'h0,         2'b11, 0, 1'b0); // ADDI
    exec_instr(32'h04, 1'b0, 1'b0, 32'h0,   32'h0,         2'b11, 0, 1'b0); // ADDI
    exec_instr(32'h08, 1'b0, 1'b1, 32'h103, 32'h0000_00AB, 2'b01, 0, 1'b0); // SB
    exec_instr(32'h0C, 1'b1, 1'b0, 32'h202, 32'h0,         2'b10, 0, 1'b0); // LH
    exec_instr(32'h10, 1'b0, 1'b1, 32'h106, 32'h1234_BEEF, 2'b10, 0, 1'b0); // SH
    exec_instr(32'h14, 1'b0, 1'b1, 32'h108, 32'hDEAD_BEEF, 2'b11, 0, 1'b0); // SW
    exec_instr(32'h18, 1'b1, 1'b0, 32'h203, 32'h0,         2'b01, 1, 1'b0); // LB
    exec_instr(32'h1C, 1'b1, 1'b1, 32'h10C, 32'h0000_005A, 2'b01, 0, 1'b0); // load+store -> store
    exec_instr(32'h20, 1'b1, 1'b0, 32'h208, 32'h0,         2'b11, 3, 1'b1); // LW, slow ack, halt

    @(negedge i_clk);
    check_eq("halt_halted", {31'd0, o_halted}, 32'd1);
    check_eq("halt_req", {31'd0, o_req}, 32'd0);
    force_ack = 1'b1;
    repeat (3) @(negedge i_clk);
    check_eq("stray_ack_inst", o_inst, mem_rd(32'h20));
    check_eq("stray_ack_rdata", o_rdata, mem_rd(32'h208));
    check_eq("stray_ack_halted", {31'd0, o_halted}, 32'd1);
    force_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    i_halt_req = 1'b0;
    exec_instr(32'h24, 1'b0, 1'b0, 32'h0,   32'h0,         2'b11, 2, 1'b0); // resume

    exec_instr(32'h28, 1'b1, 1'b0, 32'h305, 32'h0,         2'b11, 0, 1'b0); // misaligned LW
    check_eq("mis_fault", {31'd0, o_fault}, 32'd1);
    check_eq("mis_cause", {30'd0, o_fault_cause}, 32'd1);
    check_eq("mis_halted", {31'd0, o_halted}, 32'd1);
    repeat (8) @(negedge i_clk);
    check_eq("mis_stays_halted", {31'd0, o_halted}, 32'd1);
    check_eq("mis_retired", o_retired, exp_retired);

    do_reset();
    exec_instr(32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 0, 1'b0);

    // fetch with no ack at all
    r_timeout_push: begin
      req_t r;
      r.maddr = 32'h04; r.we = 1'b0; r.wstrb = 4'h0; r.mwdata = '0;
      req_q.push_back(r);
    end
    i_pc = 32'h04; ack_delay = 1000;
    reqs = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge i_clk);
      if (o_req) reqs++;
    end
    check_eq("to_req_cycles", reqs, 32'd4);
    check_eq("to_fault", {31'd0, o_fault}, 32'd1);
    check_eq("to_cause", {30'd0, o_fault_cause}, 32'd2);
    check_eq("to_halted", {31'd0, o_halted}, 32'd1);
    check_eq("to_retired", o_retired, exp_retired);
    req_q.delete();

    do_reset();
    r_midreq_push: begin
      req_t r;
      r.maddr = 32'h00; r.we = 1'b0; r.wstrb = 4'h0; r.mwdata = '0;
      req_q.push_back(r);
    end
    ack_delay = 1000;
    @(negedge i_clk);
    check_eq("midreq_req_up", {31'd0, o_req}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_eq("midreq_req_drop", {31'd0, o_req}, 32'd0);
    req_q.delete();
    check_eq("commit_queue_empty", cm_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
